maze_move_arbiter: RTL

MAZE_MOVE_ARBITER -- requirements
Module: maze_move_arbiter

---
 rtl/maze_move_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/maze_move_arbiter.sv
// Round-robin move-query arbiter: per granted ghost, reads the four neighbour tiles from a
// synchronous maze ROM and reports passability. Define GHOST_DOOR_EN to let ghosts pass doors going UP.
module maze_move_arbiter #(
  parameter int MAZE_W     = 28,
  parameter int MAZE_H     = 36,
  parameter int TUNNEL_ROW = 19
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [23:0] ghostX,
  input  logic [23:0] ghostY,
  output logic [3:0]  ack,
  output logic [15:0] canMove,
  output logic [9:0]  mazeAddr,
  input  logic [1:0]  mazeData
);

  typedef enum logic [1:0] {StIdle, StLook, StDrain, StResp} state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [5:0]  x_q, x_d, y_q, y_d;
  logic [2:0]  wall_q, wall_d, door_q, door_d;
  logic [3:0]  oob_q, oob_d;
  logic [3:0]  ack_q, ack_d;
  logic [15:0] can_q, can_d;
  logic [9:0]  addr_q, addr_d;

  logic [3:0]  req_m;
  logic        found;
  logic [1:0]  sel, idx;
  logic [3:0]  wall_v, door_v, pass;
  logic [10:0] nb;

  // Returns {out_of_bounds, tile address}; out-of-bounds neighbours read address 0.
  function automatic logic [10:0] nb_addr(input logic [5:0] x, input logic [5:0] y,
                                          input logic [1:0] d);
    int   nx;
    int   ny;
    logic oob;
    nx = int'(x);
    ny = int'(y);
    case (d)
      2'd0:    ny = ny - 1;
      2'd1:    nx = nx + 1;
      2'd2:    ny = ny + 1;
      default: nx = nx - 1;
    endcase
    if (ny == TUNNEL_ROW) begin
      if (nx < 0) nx = MAZE_W - 1;
      else if (nx == MAZE_W) nx = 0;
    end
    oob = (nx < 0) || (nx >= MAZE_W) || (ny < 0) || (ny >= MAZE_H);
    return {oob, oob ? 10'd0 : 10'(ny * MAZE_W + nx)};
  endfunction

  // The ghost being acked this cycle is masked so it cannot win the back-to-back grant.
  always_comb begin
    req_m = (state_q == StResp) ? (req & ~ack_q) : req;
    found = 1'b0;
    sel   = ptr_q;
    idx   = ptr_q;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req_m[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // LEFT data arrives in DRAIN and is used straight off the ROM bus.
  always_comb begin
    wall_v = {mazeData[0], wall_q};
    door_v = {mazeData[1], door_q};
    pass   = '0;
    for (int d = 0; d < 4; d++) begin
`ifdef GHOST_DOOR_EN
      pass[d] = !oob_q[d] && !wall_v[d] && (!door_v[d] || (d == 0));
`else
      pass[d] = !oob_q[d] && !wall_v[d] && !door_v[d];
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    x_d     = x_q;
    y_d     = y_q;
    wall_d  = wall_q;
    door_d  = door_q;
    oob_d   = oob_q;
    ack_d   = '0;
    can_d   = can_q;
    addr_d  = addr_q;
    nb      = '0;

    case (state_q)
      StLook: begin
        if (cnt_q != 2'd0) begin
          wall_d[cnt_q - 2'd1] = mazeData[0];
          door_d[cnt_q - 2'd1] = mazeData[1];
        end
        if (cnt_q == 2'd3) begin
          state_d = StDrain;
        end else begin
          cnt_d        = cnt_q + 2'd1;
          nb           = nb_addr(x_q, y_q, cnt_d);
          addr_d       = nb[9:0];
          oob_d[cnt_d] = nb[10];
        end
      end
      StDrain: begin
        state_d            = StResp;
        ack_d              = 4'b0001 << gnt_q;
        can_d[4*gnt_q +: 4] = pass;
      end
      default: ;
    endcase

    if ((state_q == StIdle || state_q == StResp) && found) begin
      state_d = StLook;
      cnt_d   = 2'd0;
      gnt_d   = sel;
      ptr_d   = sel + 2'd1;
      x_d     = ghostX[6*sel +: 6];
      y_d     = ghostY[6*sel +: 6];
      nb      = nb_addr(x_d, y_d, 2'd0);
      addr_d  = nb[9:0];
      oob_d   = {3'b000, nb[10]};
    end else if (state_q == StResp) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      gnt_q   <= '0;
      ptr_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      wall_q  <= '0;
      door_q  <= '0;
      oob_q   <= '0;
      ack_q   <= '0;
      can_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      wall_q  <= wall_d;
      door_q  <= door_d;
      oob_q   <= oob_d;
      ack_q   <= ack_d;
      can_q   <= can_d;
      addr_q  <= addr_d;
    end
  end

  assign ack      = ack_q;
  assign canMove  = can_q;
  assign mazeAddr = addr_q;

endmodule
